// File: rtl/step_ctrl.sv
// step_ctrl -- run/pause/single-step controller for the CPU core.
//
// Samples the divider's slow fp_clk as data in the clk domain and turns each
// rising edge into a one-cycle tick. Two debounced buttons toggle run/pause
// and request single steps. The core is gated with the registered one-cycle
// enable cpu_ce, so it stays on clk and advances one instruction per enable.
//
// Optional feature macro: STEP_DEBOUNCE_EN
//   defined   -> each button gets a counter debouncer honouring DB_CYCLES
//   undefined -> the synchronized level is used directly (fast sim build)
//
// Reset is synchronous and active when rst == `RstEnable (defaults to 1'b1).
//
// step_ctrl ports:
//   clk        in   system clock (shared with divider and core)
//   rst        in   synchronous reset, active high
//   fp_clk     in   slow square wave from the divider, asynchronous data
//   btn_pause  in   raw button, each press toggles run/pause
//   btn_step   in   raw button, one step request while paused
//   cpu_ce     out  registered one-cycle enable to the core
//   running    out  high in RUN state (status LED)
//   step_cnt   out  number of cpu_ce pulses since reset, wraps
//
// step_ctrl_btn ports:
//   clk, rst   as above
//   btn        in   raw button level
//   press      out  registered one-cycle pulse on a debounced rising edge

`ifndef RstEnable
`define RstEnable 1'b1
`endif

module step_ctrl_btn #(
    parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    logic s0, s1;   // 2-flop synchronizer
    logic db;       // accepted button level
    logic db_q;     // previous accepted level for edge detect

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= btn;
            s1 <= s0;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    logic [19:0] dc;

    // A new level is accepted only after DB_CYCLES consecutive samples that
    // disagree with the current one; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            db <= 1'b0;
            dc <= 20'd0;
        end else if (s1 != db) begin
            if (dc == DB_CYCLES - 20'd1) begin
                db <= s1;
                dc <= 20'd0;
            end else begin
                dc <= dc + 20'd1;
            end
        end else begin
            dc <= 20'd0;
        end
    end
`else
    assign db = s1;
`endif

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            db_q  <= 1'b0;
            press <= 1'b0;
        end else begin
            db_q  <= db;
            press <= db & ~db_q;
        end
    end

    // Below 2 the debouncer's terminal count would never be reached cleanly.
    generate
        if (DB_CYCLES < 20'd2) begin : g_db_range
            $error("step_ctrl_btn: DB_CYCLES must be at least 2");
        end
    endgenerate
endmodule

module step_ctrl #(
    parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fp_clk,
    input  logic        btn_pause,
    input  logic        btn_step,
    output logic        cpu_ce,
    output logic        running,
    output logic [31:0] step_cnt
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        PAUSE     = 2'd1,
        STEP_WAIT = 2'd2
    } state_t;

    state_t state;

    // fp_clk: f0/f1 resynchronize, f2 delays f1 for the rising-edge detect.
    logic f0, f1, f2;
    logic tick;

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            f0 <= 1'b0;
            f1 <= 1'b0;
            f2 <= 1'b0;
        end else begin
            f0 <= fp_clk;
            f1 <= f0;
            f2 <= f1;
        end
    end

    assign tick = f1 & ~f2;

    // Button channels: index 0 = pause, index 1 = step.
    logic [1:0] btn_raw;
    logic [1:0] press;
    logic       pause_press, step_press;

    assign btn_raw = {btn_step, btn_pause};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_btn
            step_ctrl_btn #(.DB_CYCLES(DB_CYCLES)) u_btn (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn_raw[i]),
                .press(press[i])
            );
        end
    endgenerate

    assign pause_press = press[0];
    assign step_press  = press[1];

    // Enable uses the state before this edge's transition, so the tick that
    // ends STEP_WAIT still produces its enable.
    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            state    <= RUN;
            cpu_ce   <= 1'b0;
            step_cnt <= 32'd0;
        end else begin
            cpu_ce <= tick & (state != PAUSE);
            if (tick && (state != PAUSE))
                step_cnt <= step_cnt + 32'd1;

            case (state)
                RUN: begin
                    if (pause_press)
                        state <= PAUSE;
                end
                PAUSE: begin
                    // Pause wins over a simultaneous step; the step is dropped.
                    if (pause_press)
                        state <= RUN;
                    else if (step_press)
                        state <= STEP_WAIT;
                end
                STEP_WAIT: begin
                    // Step presses here are ignored rather than queued.
                    if (pause_press)
                        state <= RUN;
                    else if (tick)
                        state <= PAUSE;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign running = (state == RUN);
endmodule

// File: doc/step_ctrl.md
# step_ctrl

Run/pause/single-step controller between the clock divider and the CPU core on the FPGA board. It samples the divider's slow `fp_clk` as data in the system clock domain and debounces the two board buttons. It issues a one-cycle clock-enable `cpu_ce` to the core, so the core keeps using `clk` and advances one instruction per enabled tick. The core can free-run at the slow rate, be frozen, or be stepped one tick at a time for observation.

## Interface
- `DB_CYCLES`, default 20'd1000000: consecutive stable samples needed to accept a new button level (10 ms at 100 MHz); legal range 2..2^20-1.
- `clk`  in  1  system clock, the same clock that drives the divider and the core.
- `rst`  in  1  synchronous, active-high reset; asserted when `rst == \`RstEnable`.
- `fp_clk`  in  1  slow square wave from the divider, treated as asynchronous data.
- `btn_pause`  in  1  raw push button, active high; each press toggles between run and pause.
- `btn_step`  in  1  raw push button, active high; requests one step while paused.
- `cpu_ce`  out  1  registered one-cycle enable to the core.
- `running`  out  1  high in RUN state; drives a status LED.
- `step_cnt`  out  32  count of `cpu_ce` pulses issued since reset; wraps 0xFFFFFFFF→0.

## Operation
- fp_clk path:
  - 3-flop chain: f0<=fp_clk, f1<=f0, f2<=f1.
  - Combinational `tick = f1 & ~f2`, one cycle per fp_clk rising edge.
- Button path, per button:
  - 2-flop synchronizer, then debouncer, then rising-edge detect of the debounced level. The edge detect yields a one-cycle `press`.
- Debouncer:
  - Holds a level `db` and a 20-bit counter `dc`.
  - If sync≠db, `dc` increments. When `dc==DB_CYCLES-1` and sync still ≠ db, `db`<=sync and `dc`<=0.
  - If sync==db, `dc`<=0.
- FSM states:
  - RUN: `pause_press`→PAUSE.
  - PAUSE:
    - `pause_press`→RUN. This wins if both presses occur in the same cycle; the step is dropped.
    - Else `step_press`→STEP_WAIT.
  - STEP_WAIT:
    - `pause_press`→RUN. The pending step is absorbed by run mode.
    - Else `tick`→PAUSE.
    - `step_press` is ignored here; it does not queue.
- Enable and counters:
  - `cpu_ce <= tick & (state==RUN | state==STEP_WAIT)`. The state used is the one present before the transition in that cycle.
  - `step_cnt <= step_cnt + 1` on every edge that loads 1 into `cpu_ce`.
  - `running` is decoded directly from the state register.
- Reset values:
  - State RUN, `cpu_ce`=0, `running`=1, `step_cnt`=0.
  - All sync flops, `db` and `dc` are 0.
- Reset behaviour:
  - Reset mid-operation aborts any pending step and takes effect at the next edge.
  - If `fp_clk` is high when reset is released, one tick follows. This is accepted behaviour.
  - A button held through reset registers one press after debounce.

## Timing
- fp_clk rise sampled at edge n means `cpu_ce` is high for exactly the cycle after edge n+2. Latency is 3 edges.
- `tick` pulses are 1 cycle wide. Back-to-back `cpu_ce` therefore requires fp_clk period ≥ 2 clk.
- Button latency from the first stable high sample to `press`:
  - 2 sync + DB_CYCLES + 1 edge.
  - The state changes on the edge after that.
- Step in PAUSE:
  - Exactly one `cpu_ce` on the first tick after entering STEP_WAIT.
  - A tick in the same cycle as `step_press` is not used.

## Configuration
- `STEP_DEBOUNCE_EN` defined: debouncers built as above, honouring `DB_CYCLES`.
- Undefined:
  - `db` is the synchronized level directly, so `press` is the rising edge of the 2-flop synchronizer output.
  - `DB_CYCLES` and `dc` are unused. This is the simulation and fast-bench build.

## Test plan
All scenarios use `DB_CYCLES`=4 and fp_clk period 20 clk, with `STEP_DEBOUNCE_EN` defined unless noted.
1. Free run: release reset and apply 5 fp_clk rises.
   - Required: 5 single-cycle `cpu_ce` pulses, each 3 edges after its rise.
   - Required: `running`=1 and `step_cnt`=5.
2. Pause: hold `btn_pause` 10 cycles.
   - Required: `running`=0 on edge 8 after the first high sample.
   - Required: no `cpu_ce` over the next 4 fp_clk rises; `step_cnt` unchanged.
3. Step: in PAUSE, hold `btn_step` 10 cycles.
   - Required: exactly one `cpu_ce` at the next fp_clk rise, then state PAUSE.
   - Required: `step_cnt`+1; a second step press repeats this.
4. Bounce: in RUN, pulse `btn_pause` high for 3 cycles.
   - Required with the macro defined: no state change.
   - Required with the macro undefined: state goes to PAUSE.
5. Simultaneous presses: in PAUSE, `pause_press` and `step_press` in the same cycle.
   - Required: state RUN and no extra `cpu_ce` beyond the normal ticks.
6. Reset mid-operation: in STEP_WAIT, assert `rst` 1 cycle.
   - Required: state RUN, `cpu_ce`=0, `step_cnt`=0 on the next edge.
